nic_fifo: RTL and testbench

- Parametrised successor to the single-slot mesh NIC; sits between one four_stage_processor and its mesh router PE port, one per mesh node.
- Replaces the one-packet input and output buffers with DEPTH-entry FIFOs in each direction.
- Adds occupancy-reporting status registers and sticky overflow flags.
- Gates injection on the router's virtual-channel polarity.

---
 rtl/nic_fifo.sv | 240 ++++++++++++++++++++++++
 tb/tb_nic_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nic_fifo.sv
// nic_fifo: mesh NIC with DEPTH-entry FIFOs in both directions.
// Sits between a four_stage_processor and its mesh router PE port.
//
// Ports:
//   clk, reset    - single clock, synchronous active-high reset
//   addr          - CPU register select
//                     0: rx head (read pops)
//                     1: rx status (read clears rx overflow)
//                     2: tx push (write)
//                     3: tx status (read clears tx overflow)
//   d_in, d_out   - CPU write / read data; reads are combinational
//   nicEn         - CPU access enable
//   nicEnWR       - 1 = write, 0 = read
//   net_si, net_di       - registered send strobe and packet to router
//   net_ri               - router ready to take a packet
//   net_so, net_do       - send strobe and packet from router
//   net_ro               - NIC can accept a packet from router
//   net_polarity         - router's current VC polarity
//
// Status word layout: [0] nonempty (rx) / full (tx), [1] overflow,
// [15:8] occupancy count. All other bits read 0.

module nic_fifo #(
   parameter int PACKET_WIDTH = 64,
   parameter int DEPTH        = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              addr,
   input  logic [PACKET_WIDTH-1:0] d_in,
   output logic [PACKET_WIDTH-1:0] d_out,
   input  logic                    nicEn,
   input  logic                    nicEnWR,
   output logic                    net_si,
   input  logic                    net_ri,
   output logic [PACKET_WIDTH-1:0] net_di,
   input  logic                    net_so,
   output logic                    net_ro,
   input  logic [PACKET_WIDTH-1:0] net_do,
   input  logic                    net_polarity
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [1:0] ADDR_RX_DATA = 2'd0;
   localparam logic [1:0] ADDR_RX_STAT = 2'd1;
   localparam logic [1:0] ADDR_TX_DATA = 2'd2;
   localparam logic [1:0] ADDR_TX_STAT = 2'd3;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PACKET_WIDTH-1:0] rx_mem_q [DEPTH];
   logic [PACKET_WIDTH-1:0] rx_mem_d [DEPTH];
   logic [PACKET_WIDTH-1:0] tx_mem_q [DEPTH];
   logic [PACKET_WIDTH-1:0] tx_mem_d [DEPTH];

   logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
   logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
   logic [CW-1:0] rx_cnt_q,    rx_cnt_d;
   logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
   logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
   logic [CW-1:0] tx_cnt_q,    tx_cnt_d;

   logic rx_ovf_q, rx_ovf_d;
   logic tx_ovf_q, tx_ovf_d;

   logic                    net_si_q, net_si_d;
   logic [PACKET_WIDTH-1:0] net_di_q, net_di_d;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic cpu_rd, cpu_wr;
   logic rx_nonempty, tx_nonempty, tx_full;
   logic rx_push, rx_pop, rx_drop;
   logic tx_push, tx_pop, tx_drop;
   logic [PACKET_WIDTH-1:0] rx_head, tx_head;

   assign cpu_rd = nicEn && !nicEnWR;
   assign cpu_wr = nicEn && nicEnWR;

   assign rx_nonempty = (rx_cnt_q != '0);
   assign tx_nonempty = (tx_cnt_q != '0);
   assign tx_full     = (tx_cnt_q == FULL_CNT);

   assign rx_head = rx_mem_q[rx_rd_ptr_q];
   assign tx_head = tx_mem_q[tx_rd_ptr_q];

   // net_ro depends only on the registered count, so a same-cycle CPU pop
   // of a full rx FIFO does not open the slot for the router until the
   // next cycle; this keeps push/pop on a full FIFO from ever colliding.
   assign net_ro  = !reset && (rx_cnt_q < FULL_CNT);
   assign rx_push = net_so && net_ro;
   assign rx_drop = net_so && !net_ro;
   assign rx_pop  = cpu_rd && (addr == ADDR_RX_DATA) && rx_nonempty;

   assign tx_push = cpu_wr && (addr == ADDR_TX_DATA) && !tx_full;
   assign tx_drop = cpu_wr && (addr == ADDR_TX_DATA) && tx_full;
   // Head-of-line blocking: only the head is eligible, so a VC mismatch
   // stalls the whole queue until the router polarity flips.
   assign tx_pop  = tx_nonempty && net_ri && (tx_head[PACKET_WIDTH-1] == net_polarity);

   // ------------------------------------------------------------------
   // Receive FIFO next state
   // ------------------------------------------------------------------
   always_comb begin
      rx_mem_d    = rx_mem_q;
      rx_wr_ptr_d = rx_wr_ptr_q;
      rx_rd_ptr_d = rx_rd_ptr_q;
      if (rx_push) begin
         rx_mem_d[rx_wr_ptr_q] = net_do;
         rx_wr_ptr_d           = rx_wr_ptr_q + AW'(1);
      end
      if (rx_pop) begin
         rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
      end
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
   end

   // ------------------------------------------------------------------
   // Transmit FIFO next state
   // ------------------------------------------------------------------
   always_comb begin
      tx_mem_d    = tx_mem_q;
      tx_wr_ptr_d = tx_wr_ptr_q;
      tx_rd_ptr_d = tx_rd_ptr_q;
      if (tx_push) begin
         tx_mem_d[tx_wr_ptr_q] = d_in;
         tx_wr_ptr_d           = tx_wr_ptr_q + AW'(1);
      end
      if (tx_pop) begin
         tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
      end
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
   end

   // ------------------------------------------------------------------
   // Router send register: net_di holds the last packet between sends
   // ------------------------------------------------------------------
   always_comb begin
      net_si_d = tx_pop;
      net_di_d = net_di_q;
      if (tx_pop) begin
         net_di_d = tx_head;
      end
   end

   // ------------------------------------------------------------------
   // Sticky overflow flags: a status read clears, a new drop in the same
   // cycle takes priority so no overflow event is ever lost.
   // ------------------------------------------------------------------
   always_comb begin
      rx_ovf_d = rx_ovf_q;
      if (cpu_rd && (addr == ADDR_RX_STAT)) begin
         rx_ovf_d = 1'b0;
      end
      if (rx_drop) begin
         rx_ovf_d = 1'b1;
      end

      tx_ovf_d = tx_ovf_q;
      if (cpu_rd && (addr == ADDR_TX_STAT)) begin
         tx_ovf_d = 1'b0;
      end
      if (tx_drop) begin
         tx_ovf_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // CPU read mux
   // ------------------------------------------------------------------
   always_comb begin
      d_out = '0;
      if (cpu_rd) begin
         case (addr)
            ADDR_RX_DATA: begin
               if (rx_nonempty) begin
                  d_out = rx_head;
               end
            end
            ADDR_RX_STAT: begin
               d_out[0]    = rx_nonempty;
               d_out[1]    = rx_ovf_q;
               d_out[15:8] = 8'(rx_cnt_q);
            end
            ADDR_TX_STAT: begin
               d_out[0]    = tx_full;
               d_out[1]    = tx_ovf_q;
               d_out[15:8] = 8'(tx_cnt_q);
            end
            default: begin
               d_out = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   // Storage needs no reset: pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      rx_mem_q <= rx_mem_d;
      tx_mem_q <= tx_mem_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         rx_cnt_q    <= '0;
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         tx_cnt_q    <= '0;
         rx_ovf_q    <= 1'b0;
         tx_ovf_q    <= 1'b0;
         net_si_q    <= 1'b0;
         net_di_q    <= '0;
      end else begin
         rx_wr_ptr_q <= rx_wr_ptr_d;
         rx_rd_ptr_q <= rx_rd_ptr_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_wr_ptr_q <= tx_wr_ptr_d;
         tx_rd_ptr_q <= tx_rd_ptr_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_ovf_q    <= rx_ovf_d;
         tx_ovf_q    <= tx_ovf_d;
         net_si_q    <= net_si_d;
         net_di_q    <= net_di_d;
      end
   end

   assign net_si = net_si_q;
   assign net_di = net_di_q;

endmodule

// File: tb/tb_nic_fifo.sv
// Scoreboard bench for nic_fifo (DEPTH=4, PACKET_WIDTH=64).
// Stimulus pushes expected router packets (with the cycle they must
// appear in) and expected CPU read data into queues; monitors at the
// falling edge pop and compare whenever the DUT presents output.

module tb_nic_fifo;

   localparam int PW = 64;

   logic          clk;
   logic          reset;
   logic [1:0]    addr;
   logic [PW-1:0] d_in;
   logic [PW-1:0] d_out;
   logic          nicEn;
   logic          nicEnWR;
   logic          net_si;
   logic          net_ri;
   logic [PW-1:0] net_di;
   logic          net_so;
   logic          net_ro;
   logic [PW-1:0] net_do;
   logic          net_polarity;

   nic_fifo #(.PACKET_WIDTH(PW), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
      .nicEn(nicEn), .nicEnWR(nicEnWR), .net_si(net_si), .net_ri(net_ri),
      .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
      .net_polarity(net_polarity)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [PW-1:0] data;
      int            at;     // expected cycle, -1 = any
   } tx_exp_t;

   tx_exp_t       tx_exp[$];
   logic [PW-1:0] rd_exp[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Router-side monitor
   always @(negedge clk) begin
      if (net_si === 1'b1) begin
         checks++;
         if (tx_exp.size() == 0) begin
            errors++;
            $display("FAIL unexpected_send: got net_di 0x%0h at cycle %0d, expected no send", net_di, cyc);
         end else begin
            tx_exp_t e;
            e = tx_exp.pop_front();
            if (net_di !== e.data || (e.at >= 0 && cyc != e.at)) begin
               errors++;
               $display("FAIL send: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                        net_di, cyc, e.data, e.at);
            end
         end
      end
   end

   // CPU read monitor
   always @(negedge clk) begin
      if (nicEn === 1'b1 && nicEnWR === 1'b0) begin
         checks++;
         if (rd_exp.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected: got 0x%0h, expected no read", d_out);
         end else begin
            logic [PW-1:0] e;
            e = rd_exp.pop_front();
            if (d_out !== e) begin
               errors++;
               $display("FAIL read addr%0d: got 0x%0h, expected 0x%0h", addr, d_out, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle of stimulus; inputs are held through the next rising edge.
   task automatic op(input bit en, input bit wr, input logic [1:0] a, input logic [PW-1:0] din,
                     input bit so, input logic [PW-1:0] ndo);
      step();
      nicEn   = en;
      nicEnWR = wr;
      addr    = a;
      d_in    = din;
      net_so  = so;
      net_do  = ndo;
   endtask

   task automatic idle();
      op(1'b0, 1'b0, 2'd0, '0, 1'b0, '0);
   endtask

   task automatic cpu_write(input logic [PW-1:0] din);
      op(1'b1, 1'b1, 2'd2, din, 1'b0, '0);
   endtask

   task automatic cpu_read(input logic [1:0] a, input logic [PW-1:0] exp);
      rd_exp.push_back(exp);
      op(1'b1, 1'b0, a, '0, 1'b0, '0);
   endtask

   task automatic rtr_push(input logic [PW-1:0] pkt);
      op(1'b0, 1'b0, 2'd0, '0, 1'b1, pkt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; addr = '0; d_in = '0; nicEn = 1'b0; nicEnWR = 1'b0;
      net_ri = 1'b0; net_so = 1'b0; net_do = '0; net_polarity = 1'b0;

      // Reset
      step(); step(); step();
      chk("net_ro_in_reset", 64'(net_ro), 64'd0);
      step();
      reset = 1'b0;
      #1;
      chk("net_ro_after_reset", 64'(net_ro), 64'd1);
      chk("net_si_after_reset", 64'(net_si), 64'd0);
      chk("net_di_after_reset", net_di, 64'd0);
      cpu_read(2'd1, 64'h0);
      cpu_read(2'd3, 64'h0);

      // Back-to-back transmit: sends appear two edges after issue
      op(1'b0, 1'b0, 2'd0, '0, 1'b0, '0);
      net_ri = 1'b1; net_polarity = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         nicEn = 1'b1; nicEnWR = 1'b1; addr = 2'd2; d_in = 64'hA0 + 64'(i);
         tx_exp.push_back('{64'hA0 + 64'(i), cyc + 2});
      end
      idle(); idle(); idle();
      cpu_read(2'd3, 64'h0);

      // VC mismatch blocks until polarity flips
      cpu_write(64'h8000_0000_0000_0001);
      idle(); idle();
      cpu_read(2'd3, 64'h100);
      idle();
      net_polarity = 1'b1;
      tx_exp.push_back('{64'h8000_0000_0000_0001, cyc + 1});
      idle(); idle(); idle();
      cpu_read(2'd3, 64'h0);

      // Router fills rx; fifth packet dropped
      for (int i = 1; i <= 5; i++) begin
         rtr_push(64'h10 + 64'(i));
         chk($sformatf("net_ro_push%0d", i), 64'(net_ro), (i <= 4) ? 64'd1 : 64'd0);
      end
      idle();
      cpu_read(2'd1, 64'h403);
      cpu_read(2'd1, 64'h401);

      // Pop while full with a dropped incoming packet
      rd_exp.push_back(64'h11);
      op(1'b1, 1'b0, 2'd0, '0, 1'b1, 64'h99);
      chk("net_ro_full", 64'(net_ro), 64'd0);
      // Simultaneous push and pop keeps count at 3
      rd_exp.push_back(64'h12);
      op(1'b1, 1'b0, 2'd0, '0, 1'b1, 64'h22);
      chk("net_ro_after_pop", 64'(net_ro), 64'd1);
      cpu_read(2'd1, 64'h303);
      cpu_read(2'd1, 64'h301);
      cpu_read(2'd0, 64'h13);
      cpu_read(2'd0, 64'h14);
      cpu_read(2'd0, 64'h22);
      cpu_read(2'd0, 64'h0);
      cpu_read(2'd1, 64'h0);

      // Tx overflow, then reset discards everything
      idle();
      net_ri = 1'b0;
      for (int i = 1; i <= 5; i++) cpu_write(64'hB0 + 64'(i));
      cpu_read(2'd3, 64'h403);
      cpu_read(2'd3, 64'h401);
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      net_ri = 1'b1; net_polarity = 1'b0;
      cpu_read(2'd3, 64'h0);
      cpu_read(2'd1, 64'h0);
      idle(); idle(); idle(); idle();

      // Reset on the edge a send would occur suppresses it
      cpu_write(64'hC1);
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("net_si_reset_inflight", 64'(net_si), 64'd0);
      idle(); idle(); idle();
      cpu_read(2'd3, 64'h0);
      idle(); idle();

      chk("tx_queue_drained", 64'(tx_exp.size()), 64'd0);
      chk("rd_queue_drained", 64'(rd_exp.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
